// File: rtl/lcd_write_sequencer.sv
// HD44780 8-bit write-only sequencer: input FIFO, power-up init, RS/E timing, column tracking.
// Define LCD_AUTOWRAP_EN to have the sequencer insert line-wrap commands after columns 15 and 31.
module lcd_write_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned T_PWR   = 1000000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 25,
  parameter int unsigned T_CMD   = 2500,
  parameter int unsigned T_CLR   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] in_word,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       busy
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned M1   = (T_PWR > T_CLR) ? T_PWR : T_CLR;
  localparam int unsigned M2   = (T_CMD > T_EN) ? T_CMD : T_EN;
  localparam int unsigned M3   = (M2 > T_SETUP) ? M2 : T_SETUP;
  localparam int unsigned TMAX = (M1 > M3) ? M1 : M3;
  localparam int unsigned CW   = $clog2(TMAX + 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_PWR, S_LOAD, S_IDLE, S_SETUP, S_EN, S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    word_q, word_d;
  logic          e_q, e_d;
  logic [2:0]    init_idx_q, init_idx_d;
  logic          init_done_q, init_done_d;
  logic          cur_init_q, cur_init_d;
  logic [4:0]    col_q, col_d;
  logic [8:0]    mem_q [DEPTH];
  logic [8:0]    mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;
  logic [8:0]    rom_word;
  logic [CW-1:0] wait_last;
`ifdef LCD_AUTOWRAP_EN
  logic          wrap_pend_q, wrap_pend_d;
  logic [8:0]    wrap_word_q, wrap_word_d;
`endif

  assign in_ready  = (count_q < FULL_CNT);
  assign lcd_rs    = word_q[8];
  assign lcd_data  = word_q[7:0];
  assign lcd_rw    = 1'b0;
  assign lcd_e     = e_q;
  assign init_done = init_done_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    rom_word = 9'h038;
    case (init_idx_q[1:0])
      2'd0:    rom_word = 9'h038;
      2'd1:    rom_word = 9'h00C;
      2'd2:    rom_word = 9'h006;
      default: rom_word = 9'h001;
    endcase
  end

  // Clear and home need the long post-write delay.
  assign wait_last = (word_q == 9'h001 || word_q == 9'h002) ? CW'(T_CLR - 1) : CW'(T_CMD - 1);

  always_comb begin
    push    = in_valid && in_ready;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) begin
      mem_d[wr_q] = in_word;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    cur_init_d  = cur_init_q;
    col_d       = col_q;
    pop         = 1'b0;
`ifdef LCD_AUTOWRAP_EN
    wrap_pend_d = wrap_pend_q;
    wrap_word_d = wrap_word_q;
`endif
    case (state_q)
      S_PWR: begin
        if (cnt_q == CW'(T_PWR - 1)) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOAD: begin
        cnt_d = '0;
        if (init_idx_q < 3'd4) begin
          word_d     = rom_word;
          init_idx_d = init_idx_q + 3'd1;
          cur_init_d = 1'b1;
          state_d    = S_SETUP;
        end
`ifdef LCD_AUTOWRAP_EN
        else if (wrap_pend_q) begin
          word_d      = wrap_word_q;
          wrap_pend_d = 1'b0;
          cur_init_d  = 1'b0;
          state_d     = S_SETUP;
        end
`endif
        else if (count_q != '0) begin
          word_d     = mem_q[rd_q];
          pop        = 1'b1;
          cur_init_d = 1'b0;
          state_d    = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
`ifdef LCD_AUTOWRAP_EN
        if (count_q != '0 || wrap_pend_q) state_d = S_LOAD;
`else
        if (count_q != '0) state_d = S_LOAD;
`endif
      end
      S_SETUP: begin
        if (cnt_q == CW'(T_SETUP - 1)) begin
          state_d = S_EN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EN: begin
        if (cnt_q == CW'(T_EN - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == wait_last) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          if (cur_init_q) begin
            if (init_idx_q == 3'd4) begin
              init_done_d = 1'b1;
              col_d       = '0;
            end
          end else if (word_q[8]) begin
`ifdef LCD_AUTOWRAP_EN
            if (col_q == 5'd31) begin
              col_d       = '0;
              wrap_pend_d = 1'b1;
              wrap_word_d = 9'h080;
            end else begin
              col_d = col_q + 5'd1;
              if (col_q == 5'd15) begin
                wrap_pend_d = 1'b1;
                wrap_word_d = 9'h0C0;
              end
            end
`else
            col_d = col_q + 5'd1;
`endif
          end else if (word_q[7:0] == 8'h01 || word_q[7:0] == 8'h02) begin
            col_d = '0;
          end else if (word_q[7:4] == 4'h8) begin
            col_d = {1'b0, word_q[3:0]};
          end else if (word_q[7:4] == 4'hC) begin
            col_d = {1'b1, word_q[3:0]};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_PWR;
        cnt_d   = '0;
      end
    endcase
    e_d = (state_d == S_EN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PWR;
      cnt_q       <= '0;
      word_q      <= '0;
      e_q         <= 1'b0;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      cur_init_q  <= 1'b0;
      col_q       <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
`ifdef LCD_AUTOWRAP_EN
      wrap_pend_q <= 1'b0;
      wrap_word_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      e_q         <= e_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      cur_init_q  <= cur_init_d;
      col_q       <= col_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
`ifdef LCD_AUTOWRAP_EN
      wrap_pend_q <= wrap_pend_d;
      wrap_word_q <= wrap_word_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer: E-pulse recorder plus vector tables and corner-case sequences.
module tb_lcd_write_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] in_word = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, lcd_rs, lcd_rw, lcd_e, init_done, busy;
  logic [7:0] lcd_data;

  lcd_write_sequencer #(
    .DEPTH(4), .T_PWR(10), .T_SETUP(1), .T_EN(2), .T_CMD(4), .T_CLR(8)
  ) dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
    .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder: one entry per E pulse, sampled on the falling clock edge.
  logic [8:0] ev_word [256];
  int         ev_rise [256];
  int         ev_fall [256];
  int         ev_n = 0, ev_nf = 0;
  int         done_cyc = 0, stab_err = 0, rw_err = 0;
  logic       e_prev = 1'b0, done_prev = 1'b0;
  logic [8:0] cur_word = '0;

  always @(negedge clk) begin
    e_prev    <= lcd_e;
    done_prev <= init_done;
    if (init_done && !done_prev) done_cyc <= cyc;
    if (lcd_e && !e_prev) begin
      ev_word[ev_n] <= {lcd_rs, lcd_data};
      ev_rise[ev_n] <= cyc;
      cur_word      <= {lcd_rs, lcd_data};
      ev_n          <= ev_n + 1;
    end
    if (!lcd_e && e_prev) begin
      ev_fall[ev_nf] <= cyc;
      ev_nf          <= ev_nf + 1;
    end
    if (lcd_e && e_prev && ({lcd_rs, lcd_data} != cur_word)) stab_err <= stab_err + 1;
    if (lcd_rw !== 1'b0) rw_err <= rw_err + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic do_reset(output int r);
    rst = 1'b1;
    @(negedge clk);
    r = cyc;
  endtask

  task automatic push_hs(input logic [8:0] w);
    int t = 0;
    in_word  = w;
    in_valid = 1'b1;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("push_timeout", int'(t < 500), 1);
    @(negedge clk);
  endtask

  task automatic wait_falls(input int target, input int budget, input string name);
    int t = 0;
    while (ev_nf < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(name, int'(ev_nf >= target), 1);
  endtask

  task automatic wait_idle(output int at, input string name);
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    at = cyc;
    chk(name, int'(busy), 0);
  endtask

  typedef struct { logic [8:0] word; int gap; } init_vec_t;
  typedef struct { logic [8:0] word; int wait_cyc; } wr_vec_t;

  init_vec_t  iv [4];
  wr_vec_t    wv [8];
  logic [8:0] fw [6];
  int         r_edge, base, base2, n_edge, at, t, exp_n;

  initial begin
    // Gap: E fall to next E rise; for the last entry, E fall to init_done.
    iv[0] = '{9'h038, 6};  iv[1] = '{9'h00C, 6};
    iv[2] = '{9'h006, 6};  iv[3] = '{9'h001, 8};
    wv[0] = '{9'h131, 4};  wv[1] = '{9'h080, 4};
    wv[2] = '{9'h001, 8};  wv[3] = '{9'h002, 8};
    wv[4] = '{9'h0C5, 4};  wv[5] = '{9'h1FF, 4};
    wv[6] = '{9'h101, 4};  wv[7] = '{9'h003, 4};
    fw[0] = 9'h141; fw[1] = 9'h142; fw[2] = 9'h143;
    fw[3] = 9'h180; fw[4] = 9'h0C3; fw[5] = 9'h15A;

    // Reset state
    @(negedge clk);
    r_edge = cyc;
    chk("rst_lcd_e", int'(lcd_e), 0);
    chk("rst_lcd_rs", int'(lcd_rs), 0);
    chk("rst_lcd_rw", int'(lcd_rw), 0);
    chk("rst_lcd_data", int'(lcd_data), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_in_ready", int'(in_ready), 1);
    base = ev_n;
    rst  = 1'b0;

    // Power-up init sequence
    wait_falls(base + 4, 200, "init_timeout");
    wait_idle(at, "init_idle_timeout");
    chk("init_first_rise", ev_rise[base] - r_edge, 12);
    for (int i = 0; i < 4; i++) begin
      chk("init_word", int'(ev_word[base+i]), int'(iv[i].word));
      chk("init_e_high", ev_fall[base+i] - ev_rise[base+i], 2);
      if (i < 3) chk("init_gap", ev_rise[base+i+1] - ev_fall[base+i], iv[i].gap);
      else       chk("init_done_gap", done_cyc - ev_fall[base+i], iv[i].gap);
    end
    chk("init_done_set", int'(init_done), 1);
    chk("init_busy_clr", int'(busy), 0);

    // Single writes into an idle sequencer
    for (int i = 0; i < 8; i++) begin
      base     = ev_n;
      in_word  = wv[i].word;
      in_valid = 1'b1;
      n_edge   = cyc + 1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("wr_bus_at_n2", int'({lcd_rs, lcd_data}), int'(wv[i].word));
      chk("wr_e_low_at_n2", int'(lcd_e), 0);
      wait_falls(base + 1, 50, "wr_timeout");
      chk("wr_e_rise", ev_rise[base] - n_edge, 3);
      chk("wr_e_high", ev_fall[base] - ev_rise[base], 2);
      chk("wr_pulse_word", int'(ev_word[base]), int'(wv[i].word));
      wait_idle(at, "wr_idle_timeout");
      chk("wr_busy_drop", at - ev_fall[base], wv[i].wait_cyc + 1);
    end

    // Six words offered back to back during the power-on wait
    do_reset(r_edge);
    rst  = 1'b0;
    base = ev_n;
    for (int k = 0; k < 4; k++) push_hs(fw[k]);
    chk("fifo_full_ready", int'(in_ready), 0);
    chk("fifo_full_elapsed", cyc - r_edge, 4);
    push_hs(fw[4]);
    push_hs(fw[5]);
    in_valid = 1'b0;
    wait_falls(base + 10, 400, "fifo_timeout");
    wait_idle(at, "fifo_idle_timeout");
    repeat (20) @(negedge clk);
    chk("fifo_pulse_count", ev_n - base, 10);
    for (int j = 0; j < 10; j++)
      chk("fifo_order", int'(ev_word[base+j]), (j < 4) ? int'(iv[j].word) : int'(fw[j-4]));

    // Clear-display delay vs. normal command delay
    base = ev_n;
    push_hs(9'h080);
    push_hs(9'h001);
    push_hs(9'h131);
    in_valid = 1'b0;
    wait_falls(base + 3, 200, "clr_timeout");
    chk("clr_word1", int'(ev_word[base+1]), 9'h001);
    chk("cmd_gap", ev_rise[base+1] - ev_fall[base], 6);
    chk("clr_gap", ev_rise[base+2] - ev_fall[base+1], 10);
    wait_idle(at, "clr_idle_timeout");

    // Seventeen characters from column 0
    do_reset(r_edge);
    rst  = 1'b0;
    base = ev_n;
    wait_falls(base + 4, 200, "wrap_init_timeout");
    wait_idle(at, "wrap_init_idle");
    base2 = ev_n;
    for (int k = 0; k < 17; k++) push_hs(9'h141);
    in_valid = 1'b0;
`ifdef LCD_AUTOWRAP_EN
    exp_n = 18;
`else
    exp_n = 17;
`endif
    wait_falls(base2 + exp_n, 1000, "wrap_timeout");
    wait_idle(at, "wrap_idle_timeout");
    repeat (20) @(negedge clk);
    chk("wrap_pulse_count", ev_n - base2, exp_n);
    chk("wrap_16th", int'(ev_word[base2+15]), 9'h141);
`ifdef LCD_AUTOWRAP_EN
    chk("wrap_17th", int'(ev_word[base2+16]), 9'h0C0);
    chk("wrap_18th", int'(ev_word[base2+17]), 9'h141);
`else
    chk("wrap_17th", int'(ev_word[base2+16]), 9'h141);
`endif

    // Reset while E is high, with words still queued
    push_hs(9'h150);
    push_hs(9'h151);
    push_hs(9'h152);
    in_valid = 1'b0;
    t = 0;
    while (!lcd_e && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_e_seen", int'(lcd_e), 1);
    do_reset(r_edge);
    chk("rst_mid_e_low", int'(lcd_e), 0);
    chk("rst_mid_ready", int'(in_ready), 1);
    chk("rst_mid_busy", int'(busy), 1);
    chk("rst_mid_init_done", int'(init_done), 0);
    chk("rst_mid_data", int'(lcd_data), 0);
    rst  = 1'b0;
    base = ev_n;
    wait_falls(base + 4, 200, "rst_mid_init_timeout");
    wait_idle(at, "rst_mid_idle_timeout");
    repeat (30) @(negedge clk);
    chk("rst_mid_first_rise", ev_rise[base] - r_edge, 12);
    chk("rst_mid_pulse_count", ev_n - base, 4);
    for (int i = 0; i < 4; i++) chk("rst_mid_init_word", int'(ev_word[base+i]), int'(iv[i].word));

    chk("bus_stable_during_e", stab_err, 0);
    chk("rw_tied_low", rw_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_write_sequencer.md
Name: lcd_write_sequencer

Overview:
- Drives the character LCD (HD44780-compatible, 8-bit bus, write-only).
- Accepts 9-bit words {rs, data[7:0]} from the keypad-to-character conversion path, where 0x1xx is a character and 0x0xx is a command.
- Buffers the words in a small FIFO, runs the power-up init sequence, and generates the RS/E timing for each write.
- Optionally inserts line-wrap commands itself; sits between the keypad/parking logic and the LCD pins.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- T_PWR, 1000000, cycles of power-on wait before the first init write (20 ms at 50 MHz).
- T_SETUP, 2, cycles RS/data are stable before E rises.
- T_EN, 25, cycles E is held high.
- T_CMD, 2500, cycles waited after E falls for a normal write.
- T_CLR, 100000, cycles waited after E falls for 0x001 or 0x002.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_word  in  9  {rs, data} to write
- in_valid  in  1  in_word valid
- in_ready  out  1  FIFO can accept; transfer when in_valid && in_ready at a clk edge
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  tied 0
- lcd_e  out  1  LCD enable strobe
- lcd_data  out  8  LCD data bus
- init_done  out  1  init sequence complete (sticky until rst)
- busy  out  1  state != S_IDLE

Behaviour:
- Reset values:
  - lcd_rs, lcd_e, lcd_rw = 0; lcd_data = 0x00; init_done = 0; busy = 1.
  - FIFO is emptied and the column counter is 0. State goes to S_PWR, init index = 0.
- Reset is synchronous. Asserting rst mid-write drops lcd_e at that edge, flushes the FIFO, and restarts from S_PWR.
- in_ready = (count < DEPTH), computed from the registered count. A push while full is ignored. A push and a pop in the same cycle leave count unchanged. Words are accepted during init.
- FSM states:
  - S_PWR: count T_PWR cycles, then go to S_LOAD.
  - S_LOAD: pick the next word by priority: init ROM (while init index < 4) > pending wrap command > FIFO head (pop). Register it onto lcd_rs/lcd_data and go to S_SETUP. If nothing is available, go to S_IDLE.
  - S_IDLE: go to S_LOAD when the FIFO is non-empty or a wrap is pending.
  - S_SETUP: T_SETUP cycles with lcd_e=0, then go to S_EN.
  - S_EN: lcd_e=1 for exactly T_EN cycles, then go to S_WAIT.
  - S_WAIT: lcd_e=0. Wait T_CLR cycles if the word was 0x001 or 0x002, otherwise T_CMD. Then go to S_LOAD.
- lcd_rs and lcd_data stay stable from S_LOAD through the end of S_WAIT.
- Init ROM, in order: 0x038, 0x00C, 0x006, 0x001. init_done rises on the cycle S_WAIT of the 4th entry ends.
- Latency, ready LCD and idle FSM, for a word pushed at edge N:
  - N+1: S_IDLE→S_LOAD.
  - N+2: lcd_rs/lcd_data valid.
  - lcd_e rises at N+2+T_SETUP.
- Column tracking, updated when a write's S_WAIT ends:
  - Data write: col+1.
  - 0x001/0x002: col=0.
  - 0x080–0x08F: col = data[3:0].
  - 0x0C0–0x0CF: col = 16 + data[3:0].
  - Other commands: col unchanged.
  - col is 5 bits; the value range is 0–31.
- Init-ROM writes do not update col; col is forced to 0 when init_done rises.

Optional Feature:
- LCD_AUTOWRAP_EN defined:
  - When col becomes 16 after a data write, a pending 0x0C0 is set.
  - When col becomes 32, a pending 0x080 is set and col = 0.
  - The pending command is issued at the next S_LOAD, before any FIFO pop, and clears when loaded.
  - If a user command lands while a wrap is pending, the wrap still issues first.
- LCD_AUTOWRAP_EN undefined:
  - No pending logic exists. Writes are passed through unchanged.
  - col still counts, but wraps 31→0 silently.

Test Plan (bench parameters: T_PWR=10, T_SETUP=1, T_EN=2, T_CMD=4, T_CLR=8, DEPTH=4):
- Release rst, no input → after 10 cycles, exactly four E pulses with data 0x38, 0x0C, 0x06, 0x01, lcd_rs=0. Each E-high lasts 2 cycles. Gap after the 4th is 8 cycles. Then init_done=1, busy=0.
- After init, push 0x131 → lcd_rs=1, lcd_data=0x31 two cycles later; E high 2 cycles starting one cycle after that; busy back to 0 after 4 wait cycles.
- Hold in_valid with 6 distinct words during S_PWR → in_ready drops after 4 accepts. All accepted words are written in order after the init pulses, none lost or duplicated.
- Push 0x080 then 0x001 → the 0x001 write waits 8 cycles (not 4) before the next E pulse.
- LCD_AUTOWRAP_EN defined, 17 pushes of 0x141 → the 17th E pulse carries 0x0C0 with lcd_rs=0 and the 18th carries 0x41. Without the macro, the 17th pulse carries 0x41.
- Assert rst for 1 cycle while lcd_e=1 → lcd_e=0 at that edge, FIFO empty, in_ready=1, init sequence restarts after 10 cycles.
